// File: rtl/doppler_buttons_debounced.sv
// doppler_buttons_debounced
//   N-channel push-button peripheral on the SoC memory bus. Each active-low pin
//   is synchronised, debounced, and its debounced press/release edges are
//   latched as sticky events that can raise a level interrupt.
//
//   Ports
//     clk, reset        system clock, asynchronous active-low reset
//     buttons_in        raw pin levels (0 = pressed), asynchronous
//     address_in        bus address, [3:2] selects DATA/EVENTS/IRQ_EN/CONFIG
//     sel_in, read_in   peripheral select, read strobe (reads are side-effect free)
//     read_value_out    combinational read data, 0 when not selected
//     write_mask_in     byte-lane write enables
//     write_value_in    write data
//     ready_out         = sel_in, single-cycle access
//     irq_out           registered |(EVENTS & IRQ_EN)

// Per-channel synchroniser + debouncer. thresh is P-1 with P=0 already folded
// to P=1 by the parent. rise/fall pulse on the clock where stable changes.
module doppler_db_lane #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pin_n,
  input  logic [W-1:0] thresh,
  output logic         stable,
  output logic         rise,
  output logic         fall
);
  logic         sync1_q, sync2_q;
  logic         stable_q, stable_d;
  logic [W-1:0] cnt_q, cnt_d;

  // cnt counts consecutive edges where the synced level disagrees with stable.
  // The >= compare means a shrunken P mid-count flips at once instead of wrapping.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q >= thresh) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= ~pin_n;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign rise   = stable_d & ~stable_q;
  assign fall   = ~stable_d & stable_q;
endmodule

module doppler_buttons_debounced #(
  parameter int NUM_BUTTONS     = 2,
  parameter int DEBOUNCE_W      = 20,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] buttons_in,
  input  logic [31:0]            address_in,
  input  logic                   sel_in,
  input  logic                   read_in,
  output logic [31:0]            read_value_out,
  input  logic [3:0]             write_mask_in,
  input  logic [31:0]            write_value_in,
  output logic                   ready_out,
  output logic                   irq_out
);
  localparam int N = NUM_BUTTONS;
  localparam int W = DEBOUNCE_W;

  logic [N-1:0] stable, rise, fall;
  logic [W-1:0] thresh;
  logic [31:0]  wm;
  logic         wr_ev, wr_en, wr_cfg;

  logic [N-1:0] pev_q, pev_d, rev_q, rev_d;
  logic [N-1:0] en_p_q, en_p_d, en_r_q, en_r_d;
  logic [W-1:0] cfg_q, cfg_d;
  logic         irq_q, irq_d;

  assign thresh = (cfg_q == '0) ? '0 : cfg_q - W'(1);

  for (genvar g = 0; g < N; g++) begin : g_lane
    doppler_db_lane #(.W(W)) u_lane (
      .clk    (clk),
      .rst_n  (reset),
      .pin_n  (buttons_in[g]),
      .thresh (thresh),
      .stable (stable[g]),
      .rise   (rise[g]),
      .fall   (fall[g])
    );
  end

  assign wm     = {{8{write_mask_in[3]}}, {8{write_mask_in[2]}},
                   {8{write_mask_in[1]}}, {8{write_mask_in[0]}}};
  assign wr_ev  = sel_in && (address_in[3:2] == 2'd1);
  assign wr_en  = sel_in && (address_in[3:2] == 2'd2);
  assign wr_cfg = sel_in && (address_in[3:2] == 2'd3);

  always_comb begin
    pev_d  = pev_q;
    rev_d  = rev_q;
    en_p_d = en_p_q;
    en_r_d = en_r_q;
    cfg_d  = cfg_q;
    // W1C first, new edges OR'd in after so a same-cycle set wins
    if (wr_ev) begin
      pev_d = pev_q & ~(write_value_in[N-1:0] & wm[N-1:0]);
      rev_d = rev_q & ~(write_value_in[16+:N] & wm[16+:N]);
    end
    pev_d = pev_d | rise;
    rev_d = rev_d | fall;
    if (wr_en) begin
      en_p_d = (en_p_q & ~wm[N-1:0]) | (write_value_in[N-1:0] & wm[N-1:0]);
      en_r_d = (en_r_q & ~wm[16+:N]) | (write_value_in[16+:N] & wm[16+:N]);
    end
    if (wr_cfg)
      cfg_d = (cfg_q & ~wm[W-1:0]) | (write_value_in[W-1:0] & wm[W-1:0]);
    irq_d = |({rev_q, pev_q} & {en_r_q, en_p_q});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pev_q  <= '0;
      rev_q  <= '0;
      en_p_q <= '0;
      en_r_q <= '0;
      cfg_q  <= W'(DEBOUNCE_CYCLES);
      irq_q  <= 1'b0;
    end else begin
      pev_q  <= pev_d;
      rev_q  <= rev_d;
      en_p_q <= en_p_d;
      en_r_q <= en_r_d;
      cfg_q  <= cfg_d;
      irq_q  <= irq_d;
    end
  end

  always_comb begin
    read_value_out = '0;
    if (sel_in) begin
      case (address_in[3:2])
        2'd0: read_value_out[N-1:0] = stable;
        2'd1: begin
          read_value_out[N-1:0] = pev_q;
          read_value_out[16+:N] = rev_q;
        end
        2'd2: begin
          read_value_out[N-1:0] = en_p_q;
          read_value_out[16+:N] = en_r_q;
        end
        default: read_value_out[W-1:0] = cfg_q;
      endcase
    end
  end

  assign ready_out = sel_in;
  assign irq_out   = irq_q;

  // Bits that carry no function: reads are side-effect free, only [3:2] decode.
  logic unused_bits;
  assign unused_bits = ^{read_in, address_in[31:4], address_in[1:0], write_value_in, wm};
endmodule

// File: tb/tb_doppler_buttons_debounced.sv
module tb_doppler_buttons_debounced;
  localparam int N  = 16;
  localparam int W  = 20;
  localparam int DC = 240000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] btn;
  logic [31:0]  addr, wdata, rdata;
  logic         sel, rd, rdy, irq;
  logic [3:0]   wmask;

  always #5 clk = ~clk;

  doppler_buttons_debounced #(.NUM_BUTTONS(N), .DEBOUNCE_W(W), .DEBOUNCE_CYCLES(DC)) dut (
    .clk            (clk),
    .reset          (rst_n),
    .buttons_in     (btn),
    .address_in     (addr),
    .sel_in         (sel),
    .read_in        (rd),
    .read_value_out (rdata),
    .write_mask_in  (wmask),
    .write_value_in (wdata),
    .ready_out      (rdy),
    .irq_out        (irq)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: a channel's debounced level follows the synced level once
  // that level has been held for at least P edges (timestamped runs, not counters).
  logic [N-1:0] m_s1, m_s2, m_prev, m_stable, m_pe, m_re, m_en_p, m_en_r;
  logic [W-1:0] m_cfg;
  logic         m_irq;
  longint       m_edge;
  longint       m_start [N];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_prev = '0; m_stable = '0;
    m_pe = '0; m_re = '0; m_en_p = '0; m_en_r = '0;
    m_cfg = W'(DC); m_irq = 1'b0; m_edge = 0;
    for (int i = 0; i < N; i++) m_start[i] = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] sp = '0;
    logic [N-1:0] sr = '0;
    logic [31:0]  wm, clr;
    longint       p;
    logic         nirq;
    m_edge++;
    p    = (m_cfg == 0) ? 1 : longint'(m_cfg);
    nirq = |({m_re, m_pe} & {m_en_r, m_en_p});
    for (int i = 0; i < N; i++) begin
      if (m_s2[i] != m_prev[i]) begin
        m_start[i] = m_edge;
        m_prev[i]  = m_s2[i];
      end
      if (m_s2[i] != m_stable[i] && (m_edge - m_start[i] + 1) >= p) begin
        m_stable[i] = m_s2[i];
        if (m_s2[i]) sp[i] = 1'b1;
        else         sr[i] = 1'b1;
      end
    end
    wm  = {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};
    clr = (sel && addr[3:2] == 2'd1) ? (wdata & wm) : 32'd0;
    m_pe = (m_pe & ~clr[N-1:0]) | sp;
    m_re = (m_re & ~clr[16+:N]) | sr;
    if (sel && addr[3:2] == 2'd2) begin
      m_en_p = (m_en_p & ~wm[N-1:0]) | (wdata[N-1:0] & wm[N-1:0]);
      m_en_r = (m_en_r & ~wm[16+:N]) | (wdata[16+:N] & wm[16+:N]);
    end
    if (sel && addr[3:2] == 2'd3)
      m_cfg = (m_cfg & ~wm[W-1:0]) | (wdata[W-1:0] & wm[W-1:0]);
    m_irq = nirq;
    m_s2  = m_s1;
    m_s1  = ~btn;
  endtask

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {16'd0, m_stable};
      2'd1:    return {m_re, m_pe};
      2'd2:    return {m_en_r, m_en_p};
      default: return {12'd0, m_cfg};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] v);
    sel = 1'b1; addr = 32'(a) << 2; wmask = 4'h0;
    #1;
    v = rdata;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] val, input logic [3:0] m);
    sel = 1'b1; addr = 32'(a) << 2; wdata = val; wmask = m;
    tick();
    wmask = 4'h0; sel = 1'b0;
  endtask

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    logic [31:0] v;
    logic [1:0]  a;
    rst_n = 1'b0; btn = '1; sel = 1'b0; addr = '0; wdata = '0; wmask = '0; rd = 1'b0;
    model_reset();
    #3;
    chk("rst_rdy0", {31'd0, rdy}, 32'd0);
    chk("rst_rd_nosel", rdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rd_reg(2'd0, v); chk("rst_data", v, 32'd0);
    rd_reg(2'd1, v); chk("rst_events", v, 32'd0);
    rd_reg(2'd2, v); chk("rst_irqen", v, 32'd0);
    rd_reg(2'd3, v); chk("rst_config", v, 32'(DC));
    chk("rst_rdy1", {31'd0, rdy}, 32'd1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; sel = 1'b0;

    // P=4 press/release latency
    wr_reg(2'd3, 32'd4, 4'hF);
    btn[0] = 1'b0;
    repeat (5) tick();
    rd_reg(2'd0, v); chk("press_5clk", v, 32'd0);
    tick();
    rd_reg(2'd0, v); chk("press_6clk", v, 32'd1);
    rd_reg(2'd1, v); chk("press_event", v, 32'h0000_0001);
    btn[0] = 1'b1;
    repeat (5) tick();
    rd_reg(2'd0, v); chk("release_5clk", v, 32'd1);
    tick();
    rd_reg(2'd0, v); chk("release_6clk", v, 32'd0);
    rd_reg(2'd1, v); chk("release_event", v, 32'h0001_0001);
    wr_reg(2'd1, 32'hFFFF_FFFF, 4'hF);
    rd_reg(2'd1, v); chk("w1c_all", v, 32'd0);

    // 3-cycle glitch shorter than P
    btn[1] = 1'b0;
    repeat (3) tick();
    btn[1] = 1'b1;
    repeat (10) tick();
    rd_reg(2'd0, v); chk("glitch_data", v, 32'd0);
    rd_reg(2'd1, v); chk("glitch_events", v, 32'd0);

    // IRQ on btn1 press, masked and unmasked W1C
    wr_reg(2'd2, 32'h0000_0002, 4'hF);
    btn[1] = 1'b0;
    repeat (6) tick();
    rd_reg(2'd1, v); chk("irq_event", v, 32'h0000_0002);
    chk("irq_pre", {31'd0, irq}, 32'd0);
    tick();
    chk("irq_set", {31'd0, irq}, 32'd1);
    wr_reg(2'd1, 32'h2, 4'b0000);
    rd_reg(2'd1, v); chk("w1c_nomask", v, 32'h0000_0002);
    chk("irq_hold", {31'd0, irq}, 32'd1);
    wr_reg(2'd1, 32'h2, 4'b0001);
    rd_reg(2'd1, v); chk("w1c_lane0", v, 32'd0);
    tick();
    chk("irq_clr", {31'd0, irq}, 32'd0);
    btn[1] = 1'b1;
    repeat (8) tick();
    wr_reg(2'd1, 32'hFFFF_FFFF, 4'hF);
    wr_reg(2'd2, 32'd0, 4'hF);

    // press edge on the same clock as W1C of bit 0
    btn[0] = 1'b0;
    repeat (5) tick();
    wr_reg(2'd1, 32'h1, 4'hF);
    rd_reg(2'd1, v); chk("set_wins", v, 32'h0000_0001);
    rd_reg(2'd0, v); chk("set_wins_data", v, 32'd1);
    btn[0] = 1'b1;
    repeat (8) tick();
    wr_reg(2'd1, 32'hFFFF_FFFF, 4'hF);
    rd_reg(2'd1, v); chk("w1c_all2", v, 32'd0);

    // all 16 pressed, then reset mid-debounce of the release
    wr_reg(2'd2, 32'h0000_FFFF, 4'hF);
    btn = '0;
    repeat (6) tick();
    rd_reg(2'd0, v); chk("all_data", v, 32'h0000_FFFF);
    rd_reg(2'd1, v); chk("all_events", v, 32'h0000_FFFF);
    btn = '1;
    repeat (3) tick();
    chk("all_irq", {31'd0, irq}, 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    rd_reg(2'd0, v); chk("mid_rst_data", v, 32'd0);
    rd_reg(2'd1, v); chk("mid_rst_events", v, 32'd0);
    rd_reg(2'd2, v); chk("mid_rst_irqen", v, 32'd0);
    rd_reg(2'd3, v); chk("mid_rst_config", v, 32'(DC));
    chk("mid_rst_irq", {31'd0, irq}, 32'd0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1; sel = 1'b0;

    // randomized traffic against the model
    wr_reg(2'd3, 32'd3, 4'hF);
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) btn[i] = ~btn[i];
      a     = 2'($urandom_range(0, 3));
      sel   = ($urandom_range(0, 7) != 0);
      addr  = ($urandom & ~32'hC) | (32'(a) << 2);
      wmask = 4'h0;
      #1;
      chk("rnd_rd", rdata, sel ? model_rd(a) : 32'd0);
      chk("rnd_irq", {31'd0, irq}, {31'd0, m_irq});
      chk("rnd_rdy", {31'd0, rdy}, {31'd0, sel});
      if ($urandom_range(0, 3) == 0) begin
        wmask = 4'($urandom);
        wdata = (a == 2'd3) ? 32'($urandom_range(0, 6)) : $urandom;
      end
      tick();
      wmask = 4'h0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
